// File: rtl/board_read_arbiter.sv
// rtl/board_read_arbiter.sv - shared board-memory read port arbiter with registered response path
//
// Arbitrates the single board_rw read port between the victory checker,
// the display scanner and the auxiliary lookahead reader. The checker has
// fixed top priority; display and aux share the remaining slots
// round-robin. Grants are combinational. The granted address is
// registered onto mem_r_row/mem_r_col (stage A), and the returned
// mem_data is registered into rsp_data with a per-requester valid strobe
// (stage B). Fixed latency from grant to valid is 2 cycles, with one
// grant per cycle and full throughput.
//
// Optional feature macro: BOARD_ARB_STARVE_EN
//   When defined, display and aux each keep a wait counter. A requester
//   whose counter has reached STARVE_LIMIT outranks the checker, and
//   display wins if both are starved. chk_lock still overrides.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   chk_req/disp_req/aux_req    read requests (held with address until gnt)
//   chk_row/disp_row/aux_row    requested row (ROW_BITS)
//   chk_col/disp_col/aux_col    requested column (COL_BITS)
//   chk_lock                    while high only the checker may be granted
//   chk_gnt/disp_gnt/aux_gnt    combinational accept, one-hot or zero
//   chk_valid/disp_valid/aux_valid  registered one-cycle response strobe
//   rsp_data                    registered response data, shared
//   mem_r_row/mem_r_col         registered read address to board_rw
//   mem_data                    combinational read data from board_rw

module board_read_arbiter #(
  parameter int ROW_BITS     = 3,
  parameter int COL_BITS     = 3,
  parameter int DATA_BITS    = 2,
  parameter int STARVE_LIMIT = 15,
  parameter int WAIT_BITS    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 chk_req,
  input  logic                 disp_req,
  input  logic                 aux_req,
  input  logic [ROW_BITS-1:0]  chk_row,
  input  logic [ROW_BITS-1:0]  disp_row,
  input  logic [ROW_BITS-1:0]  aux_row,
  input  logic [COL_BITS-1:0]  chk_col,
  input  logic [COL_BITS-1:0]  disp_col,
  input  logic [COL_BITS-1:0]  aux_col,
  input  logic                 chk_lock,
  output logic                 chk_gnt,
  output logic                 disp_gnt,
  output logic                 aux_gnt,
  output logic                 chk_valid,
  output logic                 disp_valid,
  output logic                 aux_valid,
  output logic [DATA_BITS-1:0] rsp_data,
  output logic [ROW_BITS-1:0]  mem_r_row,
  output logic [COL_BITS-1:0]  mem_r_col,
  input  logic [DATA_BITS-1:0] mem_data
);

  // Owner tag carried alongside the stage A address.
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CHK  = 2'd1;
  localparam logic [1:0] OWN_DISP = 2'd2;
  localparam logic [1:0] OWN_AUX  = 2'd3;

  // The wait counters must be able to reach STARVE_LIMIT.
  if (STARVE_LIMIT >= (1 << WAIT_BITS)) begin : g_bad_cfg
    $error("WAIT_BITS too narrow to hold STARVE_LIMIT");
  end

  logic       rr_aux;        // 0: display favoured on a tie, 1: aux favoured
  logic       disp_starved;
  logic       aux_starved;
  logic [1:0] a_owner;

`ifdef BOARD_ARB_STARVE_EN
  localparam logic [WAIT_BITS-1:0] LIMIT = WAIT_BITS'(STARVE_LIMIT);

  logic [WAIT_BITS-1:0] disp_wait;
  logic [WAIT_BITS-1:0] aux_wait;

  assign disp_starved = disp_req && (disp_wait == LIMIT);
  assign aux_starved  = aux_req  && (aux_wait  == LIMIT);

  // Count only cycles spent waiting; any grant or dropped request restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_wait <= '0;
      aux_wait  <= '0;
    end else begin
      if (!disp_req || disp_gnt)
        disp_wait <= '0;
      else if (disp_wait != LIMIT)
        disp_wait <= disp_wait + 1'b1;

      if (!aux_req || aux_gnt)
        aux_wait <= '0;
      else if (aux_wait != LIMIT)
        aux_wait <= aux_wait + 1'b1;
    end
  end
`else
  assign disp_starved = 1'b0;
  assign aux_starved  = 1'b0;
`endif

  // Grant selection. Depends only on requests, lock and local state, so
  // there is no path from one requester's req back to another's req.
  always_comb begin
    chk_gnt  = 1'b0;
    disp_gnt = 1'b0;
    aux_gnt  = 1'b0;
    if (chk_lock)
      chk_gnt = chk_req;
    else if (disp_starved)
      disp_gnt = 1'b1;
    else if (aux_starved)
      aux_gnt = 1'b1;
    else if (chk_req)
      chk_gnt = 1'b1;
    else if (disp_req && (!aux_req || !rr_aux))
      disp_gnt = 1'b1;
    else if (aux_req)
      aux_gnt = 1'b1;
  end

  // Round-robin pointer: after serving one of disp/aux, favour the other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr_aux <= 1'b0;
    else if (disp_gnt)
      rr_aux <= 1'b1;
    else if (aux_gnt)
      rr_aux <= 1'b0;
  end

  // Stage A: registered read address plus owner tag. The address holds
  // when nothing is granted; the tag drops to NONE so no response follows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r_row <= '0;
      mem_r_col <= '0;
      a_owner   <= OWN_NONE;
    end else begin
      if (chk_gnt) begin
        mem_r_row <= chk_row;
        mem_r_col <= chk_col;
        a_owner   <= OWN_CHK;
      end else if (disp_gnt) begin
        mem_r_row <= disp_row;
        mem_r_col <= disp_col;
        a_owner   <= OWN_DISP;
      end else if (aux_gnt) begin
        mem_r_row <= aux_row;
        mem_r_col <= aux_col;
        a_owner   <= OWN_AUX;
      end else begin
        a_owner   <= OWN_NONE;
      end
    end
  end

  // Stage B: capture board data and raise the owner's strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data   <= '0;
      chk_valid  <= 1'b0;
      disp_valid <= 1'b0;
      aux_valid  <= 1'b0;
    end else begin
      chk_valid  <= (a_owner == OWN_CHK);
      disp_valid <= (a_owner == OWN_DISP);
      aux_valid  <= (a_owner == OWN_AUX);
      if (a_owner != OWN_NONE)
        rsp_data <= mem_data;
    end
  end

endmodule

// File: tb/tb_board_read_arbiter.sv
// tb/tb_board_read_arbiter.sv - self-checking bench for board_read_arbiter

module tb_board_read_arbiter;

  localparam int RB    = 3;
  localparam int CB    = 3;
  localparam int DB    = 2;
  localparam int LIMIT = 15;
`ifdef BOARD_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          chk_req, disp_req, aux_req, chk_lock;
  logic [RB-1:0] chk_row, disp_row, aux_row;
  logic [CB-1:0] chk_col, disp_col, aux_col;
  logic          chk_gnt, disp_gnt, aux_gnt;
  logic          chk_valid, disp_valid, aux_valid;
  logic [DB-1:0] rsp_data, mem_data;
  logic [RB-1:0] mem_r_row;
  logic [CB-1:0] mem_r_col;

  logic [DB-1:0] board [64];

  always #5 clk = ~clk;

  assign mem_data = board[{mem_r_row, mem_r_col}];

  board_read_arbiter #(
    .ROW_BITS(RB), .COL_BITS(CB), .DATA_BITS(DB), .STARVE_LIMIT(LIMIT), .WAIT_BITS(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .chk_req(chk_req), .disp_req(disp_req), .aux_req(aux_req),
    .chk_row(chk_row), .disp_row(disp_row), .aux_row(aux_row),
    .chk_col(chk_col), .disp_col(disp_col), .aux_col(aux_col),
    .chk_lock(chk_lock),
    .chk_gnt(chk_gnt), .disp_gnt(disp_gnt), .aux_gnt(aux_gnt),
    .chk_valid(chk_valid), .disp_valid(disp_valid), .aux_valid(aux_valid),
    .rsp_data(rsp_data), .mem_r_row(mem_r_row), .mem_r_col(mem_r_col),
    .mem_data(mem_data)
  );

  int errors = 0;
  int checks = 0;
  int cyc_no = 0;

  // Reference model: owners 0 none, 1 chk, 2 disp, 3 aux.
  typedef struct {int owner; int data; int due;} rsp_t;
  rsp_t pend[$];
  int m_fav;           // requester favoured on a disp/aux tie (2 or 3)
  int m_dw, m_aw;      // cycles each has waited
  int m_row, m_col;    // address expected on the memory port
  int m_data;          // last response data

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    m_fav  = 2;
    m_dw   = 0;
    m_aw   = 0;
    m_row  = 0;
    m_col  = 0;
    m_data = 0;
  endtask

  function automatic int pick(bit c, bit d, bit a, bit l);
    if (l) return c ? 1 : 0;
    if (STARVE && d && m_dw >= LIMIT) return 2;
    if (STARVE && a && m_aw >= LIMIT) return 3;
    if (c) return 1;
    if (d && a) return m_fav;
    if (d) return 2;
    if (a) return 3;
    return 0;
  endfunction

  // One clock cycle, entered at posedge+1: drive, check, advance model.
  task automatic cyc(input bit c, input bit d, input bit a, input bit l, output logic [2:0] g);
    int w;
    int ev;
    chk_req = c; disp_req = d; aux_req = a; chk_lock = l;
    #1;
    w = pick(c, d, a, l);
    g = {aux_gnt, disp_gnt, chk_gnt};
    check("chk_gnt", chk_gnt, w == 1);
    check("disp_gnt", disp_gnt, w == 2);
    check("aux_gnt", aux_gnt, w == 3);
    ev = 0;
    if (pend.size() > 0 && pend[0].due == cyc_no) begin
      ev     = pend[0].owner;
      m_data = pend[0].data;
      void'(pend.pop_front());
    end
    check("chk_valid", chk_valid, ev == 1);
    check("disp_valid", disp_valid, ev == 2);
    check("aux_valid", aux_valid, ev == 3);
    check("rsp_data", rsp_data, m_data);
    check("mem_r_row", mem_r_row, m_row);
    check("mem_r_col", mem_r_col, m_col);
    if (w == 1) begin m_row = chk_row;  m_col = chk_col;  end
    if (w == 2) begin m_row = disp_row; m_col = disp_col; end
    if (w == 3) begin m_row = aux_row;  m_col = aux_col;  end
    if (w != 0) pend.push_back('{owner: w, data: int'(board[m_row * 8 + m_col]), due: cyc_no + 2});
    if (w == 2) m_fav = 3;
    if (w == 3) m_fav = 2;
    m_dw = (d && w != 2) ? ((m_dw + 1 > LIMIT) ? LIMIT : m_dw + 1) : 0;
    m_aw = (a && w != 3) ? ((m_aw + 1 > LIMIT) ? LIMIT : m_aw + 1) : 0;
    @(posedge clk);
    #1;
    cyc_no++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    chk_req = 0; disp_req = 0; aux_req = 0; chk_lock = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    check("rst_mem_r_row", mem_r_row, 0);
    check("rst_mem_r_col", mem_r_col, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_valids", {chk_valid, disp_valid, aux_valid}, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] g;
    int first;
    bit cr, dr, ar;

    for (int i = 0; i < 64; i++) board[i] = DB'($urandom_range(0, 3));
    board[2 * 8 + 5] = 2'b10;
    chk_row = 0; chk_col = 0; disp_row = 0; disp_col = 0; aux_row = 0; aux_col = 0;
    do_reset();
    check("rst_gnt_idle", {chk_gnt, disp_gnt, aux_gnt}, 0);

    // Single display read at (2,5).
    disp_row = 3'd2; disp_col = 3'd5;
    cyc(0, 1, 0, 0, g);
    check("single_gnt", g, 3'b010);
    cyc(0, 0, 0, 0, g);
    cyc(0, 0, 0, 0, g);
    cyc(0, 0, 0, 0, g);

    // Priority then round-robin.
    do_reset();
    chk_row = 3'd1; chk_col = 3'd1; aux_row = 3'd7; aux_col = 3'd0;
    for (int i = 0; i < 6; i++) begin
      cyc(1, 1, 1, 0, g);
      check("prio_chk", g, 3'b001);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 1, 0, g);
      check("rr_alt", g, (i % 2 == 0) ? 3'b010 : 3'b100);
    end
    cyc(0, 0, 0, 0, g);
    cyc(0, 0, 0, 0, g);

    // Lock blocks display, release grants immediately.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 0, 1, g);
      check("lock_none", g, 3'b000);
    end
    cyc(0, 1, 0, 0, g);
    check("lock_release", g, 3'b010);
    cyc(0, 0, 0, 0, g);
    cyc(0, 0, 0, 0, g);

    // Starvation of display behind the checker.
    do_reset();
    first = 0;
    for (int i = 1; i <= (STARVE ? 20 : 100); i++) begin
      cyc(1, 1, 0, 0, g);
      if (g[1] && first == 0) first = i;
    end
    check("starve_first", first, STARVE ? 16 : 0);
    cyc(0, 0, 0, 0, g);
    cyc(0, 0, 0, 0, g);

    // Back-to-back chk, disp, chk.
    do_reset();
    chk_row = 3'd4; chk_col = 3'd6; disp_row = 3'd2; disp_col = 3'd5;
    cyc(1, 0, 0, 0, g);
    check("b2b_0", g, 3'b001);
    chk_row = 3'd0; chk_col = 3'd3;
    cyc(0, 1, 0, 0, g);
    check("b2b_1", g, 3'b010);
    cyc(1, 0, 0, 0, g);
    check("b2b_2", g, 3'b001);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, g);

    // Reset the cycle after a grant: in-flight read is dropped.
    cyc(0, 1, 0, 0, g);
    rst_n = 1'b0;
    #1;
    check("midrst_row", mem_r_row, 0);
    check("midrst_col", mem_r_col, 0);
    check("midrst_valid", disp_valid, 0);
    do_reset();
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, g);

    // Randomized traffic honouring the hold-until-grant handshake.
    cr = 0; dr = 0; ar = 0;
    for (int i = 0; i < 400; i++) begin
      if (!cr && $urandom_range(0, 2) == 0) begin
        cr = 1; chk_row = RB'($urandom_range(0, 7)); chk_col = CB'($urandom_range(0, 7));
      end
      if (!dr && $urandom_range(0, 1) == 0) begin
        dr = 1; disp_row = RB'($urandom_range(0, 7)); disp_col = CB'($urandom_range(0, 7));
      end
      if (!ar && $urandom_range(0, 1) == 0) begin
        ar = 1; aux_row = RB'($urandom_range(0, 7)); aux_col = CB'($urandom_range(0, 7));
      end
      cyc(cr, dr, ar, ($urandom_range(0, 9) == 0), g);
      if (g[0]) cr = 0;
      if (g[1]) dr = 0;
      if (g[2]) ar = 0;
    end
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, g);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
